// File: rtl/seg_pkg.sv
// Shared types and constants for the segment digit sequencer: active-low
// 7-segment code type and the hex decode table, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK_ZERO = 7'b1000000;

    localparam seg7_t SEG_DECODE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code; zero latency.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg7_t      o_seg
);

    assign o_seg = SEG_DECODE[i_nib];

endmodule

// File: rtl/seg_digit_sequencer.sv
// Sliding window of NUM_DISPLAYS digits over a writable NUM_DIGITS sequence; hex is
// registered (step event -> pos +1 cycle -> hex +2). SEG_SEQ_AUTO_STEP_EN adds the prescaled auto step.
module seg_digit_sequencer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int NUM_DISPLAYS = 1,
    parameter int PRESCALE     = 50_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_step,
    input  logic                          i_dir,
    input  logic                          i_auto_mode,
    input  logic                          i_wr_en,
    input  logic [3:0]                    i_wr_addr,
    input  logic [3:0]                    i_wr_data,
    output logic [$clog2(NUM_DIGITS)-1:0] o_pos,
    output logic [7*NUM_DISPLAYS-1:0]     o_hex
);

    localparam int PW = $clog2(NUM_DIGITS);

    logic                    r_step_q;
    logic                    w_step_evt;
    logic                    w_tick;
    logic                    w_adv;
    logic [PW-1:0]           r_pos;
    logic [3:0]              r_digits [NUM_DIGITS];
    logic [7*NUM_DISPLAYS-1:0] w_seg_all;
    logic [7*NUM_DISPLAYS-1:0] r_hex;

    assign w_step_evt = i_step & ~r_step_q;

    always_ff @(posedge clk) begin
        if (reset) r_step_q <= 1'b0;
        else       r_step_q <= i_step;
    end

`ifdef SEG_SEQ_AUTO_STEP_EN
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] r_presc;

    assign w_tick = i_auto_mode && (r_presc == CW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset || !i_auto_mode || w_tick) r_presc <= '0;
        else                                 r_presc <= r_presc + CW'(1);
    end
`else
    logic w_unused;

    assign w_unused = i_auto_mode | (PRESCALE == 0);
    assign w_tick   = 1'b0;
`endif

    // A manual event and an auto tick landing together still move one position.
    assign w_adv = w_step_evt | w_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos <= '0;
        end else if (w_adv) begin
            if (i_dir) r_pos <= (r_pos == PW'(NUM_DIGITS - 1)) ? '0 : r_pos + PW'(1);
            else       r_pos <= (r_pos == '0) ? PW'(NUM_DIGITS - 1) : r_pos - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (reset)
                r_digits[i] <= 4'h0;
            else if (i_wr_en && i_wr_addr == 4'(i))
                r_digits[i] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < NUM_DISPLAYS; k++) begin : g_disp
        logic [PW:0] w_sum;
        logic [PW:0] w_idx;
        logic [3:0]  w_nib;
        seg7_t       w_seg;

        assign w_sum = {1'b0, r_pos} + (PW+1)'(k);
        assign w_idx = (w_sum >= (PW+1)'(NUM_DIGITS)) ? w_sum - (PW+1)'(NUM_DIGITS) : w_sum;

        always_comb begin
            w_nib = 4'h0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_idx == (PW+1)'(i)) w_nib = r_digits[i];
            end
        end

        seg_hex_decode u_dec (
            .i_nib (w_nib),
            .o_seg (w_seg)
        );

        assign w_seg_all[7*k +: 7] = w_seg;
    end

    always_ff @(posedge clk) begin
        if (reset) r_hex <= {NUM_DISPLAYS{SEG_BLANK_ZERO}};
        else       r_hex <= w_seg_all;
    end

    assign o_pos = r_pos;
    assign o_hex = r_hex;

endmodule

// File: tb/tb_seg_digit_sequencer.sv
// Directed bench: one- and three-display instances share stimulus; expected
// segment codes are hand-written constants.
module tb_seg_digit_sequencer;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step = 1'b0;
    logic        dir = 1'b1;
    logic        auto_mode = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'h0;
    logic [3:0]  wr_data = 4'h0;
    logic [2:0]  pos1, pos3;
    logic [6:0]  hex1;
    logic [20:0] hex3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg_digit_sequencer #(.NUM_DIGITS(5), .NUM_DISPLAYS(1), .PRESCALE(4)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .i_step      (step),
        .i_dir       (dir),
        .i_auto_mode (auto_mode),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_pos       (pos1),
        .o_hex       (hex1)
    );

    seg_digit_sequencer #(.NUM_DIGITS(5), .NUM_DISPLAYS(3), .PRESCALE(4)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .i_step      (step),
        .i_dir       (dir),
        .i_auto_mode (auto_mode),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_pos       (pos3),
        .o_hex       (hex3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        step = 1'b1;
        tick(2);
        step = 1'b0;
        tick(2);
    endtask

    logic [3:0] seq_dat [5] = '{4'h5, 4'h2, 4'h8, 4'h4, 4'h9};
    logic [6:0] fwd_seg [5] = '{S2, S8, S4, S9, S5};

    initial begin
        tick(2);
        reset = 1'b0;
        chk("rst_pos", 32'(pos1), 32'd0);
        chk("rst_hex1", 32'(hex1), 32'(S0));
        chk("rst_hex3", 32'(hex3), 32'({S0, S0, S0}));

        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = seq_dat[i];
            tick(1);
        end
        wr_en = 1'b0;
        tick(1);
        chk("wr_hex1", 32'(hex1), 32'(S5));

        dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse();
            chk($sformatf("fwd_pos%0d", i), 32'(pos1), (i == 4) ? 32'd0 : 32'(i + 1));
            chk($sformatf("fwd_hex%0d", i), 32'(hex1), 32'(fwd_seg[i]));
        end

        dir = 1'b0;
        pulse();
        chk("bwd_wrap_pos", 32'(pos1), 32'd4);
        chk("bwd_wrap_hex", 32'(hex1), 32'(S9));

        step = 1'b1;
        tick(10);
        step = 1'b0;
        tick(2);
        chk("hold_pos", 32'(pos1), 32'd3);
        chk("win3_pos", 32'(pos3), 32'd3);
        chk("win3_hex", 32'(hex3), 32'({S5, S9, S4}));

        wr_en   = 1'b1;
        wr_addr = 4'd7;
        wr_data = 4'hF;
        tick(1);
        wr_en = 1'b0;
        tick(1);
        chk("oob_hex3", 32'(hex3), 32'({S5, S9, S4}));
        chk("oob_hex1", 32'(hex1), 32'(S4));

        dir     = 1'b1;
        step    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd4;
        wr_data = 4'hA;
        tick(1);
        wr_en = 1'b0;
        chk("wrstep_pos", 32'(pos1), 32'd4);
        tick(1);
        chk("wrstep_hex1", 32'(hex1), 32'(SA));
        chk("wrstep_hex3", 32'(hex3), 32'({S2, S5, SA}));
        step = 1'b0;
        tick(1);

`ifdef SEG_SEQ_AUTO_STEP_EN
        auto_mode = 1'b1;
        tick(3);
        chk("auto_pre_pos", 32'(pos1), 32'd4);
        tick(1);
        chk("auto_t1_pos", 32'(pos1), 32'd0);
        tick(4);
        chk("auto_t2_pos", 32'(pos1), 32'd1);
        tick(3);
        step = 1'b1;
        tick(1);
        chk("auto_coinc_pos", 32'(pos1), 32'd2);
        step = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("auto_rst_pos", 32'(pos1), 32'd0);
        chk("auto_rst_hex1", 32'(hex1), 32'(S0));
        chk("auto_rst_hex3", 32'(hex3), 32'({S0, S0, S0}));
        reset     = 1'b0;
        auto_mode = 1'b0;
        tick(2);
`else
        auto_mode = 1'b1;
        tick(10);
        chk("noauto_pos", 32'(pos1), 32'd4);
        auto_mode = 1'b0;
        reset = 1'b1;
        tick(1);
        chk("rst2_pos", 32'(pos1), 32'd0);
        chk("rst2_hex1", 32'(hex1), 32'(S0));
        reset = 1'b0;
        tick(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
